// File: rtl/dip14_chip_emulator_pkg.sv
// dip14_chip_emulator_pkg: chip codes, FSM states, pin indices and output-pin masks for the DIP14 emulator
package dip14_chip_emulator_pkg;
  typedef enum logic [2:0] {
    CHIP_NONE, CHIP_7400, CHIP_7402, CHIP_7404, CHIP_7408, CHIP_7432, CHIP_7486, CHIP_7474
  } chip_e;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACTIVE} state_e;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P3 = 2;
  localparam int P4 = 3;
  localparam int P5 = 4;
  localparam int P6 = 5;
  localparam int P8 = 6;
  localparam int P9 = 7;
  localparam int P10 = 8;
  localparam int P11 = 9;
  localparam int P12 = 10;
  localparam int P13 = 11;
  localparam logic [11:0] MASK_QUAD = 12'h264;
  localparam logic [11:0] MASK_NOR = 12'h909;
  localparam logic [11:0] MASK_INV = 12'h56A;
  localparam logic [11:0] MASK_FF = 12'h0F0;
  function automatic logic [11:0] out_mask(chip_e c);
    return (c == CHIP_NONE) ? 12'h000 :
           (c == CHIP_7402) ? MASK_NOR :
           (c == CHIP_7404) ? MASK_INV :
           (c == CHIP_7474) ? MASK_FF : MASK_QUAD;
  endfunction
  function automatic logic gate(chip_e c, logic a, logic b);
    return (c == CHIP_7400) ? ~(a & b) :
           (c == CHIP_7408) ? (a & b) :
           (c == CHIP_7432) ? (a | b) :
           (c == CHIP_7486) ? (a ^ b) : 1'b0;
  endfunction
  // Pin numbers 7 and 14 are supplies, so pins 8..13 sit two below their number.
  function automatic logic [11:0] pin_bit(logic [3:0] p);
    return (p >= 4'd1 && p <= 4'd6) ? 12'd1 << (p - 4'd1) :
           (p >= 4'd8 && p <= 4'd13) ? 12'd1 << (p - 4'd2) : 12'd0;
  endfunction
endpackage

// File: rtl/dip14_chip_emulator_pin_sync.sv
// dip14_chip_emulator_pin_sync: multi-stage synchronizer for the checker-driven pin vector
module dip14_chip_emulator_pin_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sr;
  always_ff @(posedge Clk) begin
    if (!Reset) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  end
  assign q = sr[STAGES-1];
endmodule

// File: rtl/dip14_chip_emulator.sv
// dip14_chip_emulator: behavioural 14-pin 74xx responder with settle window and single-pin fault injection
module dip14_chip_emulator
  import dip14_chip_emulator_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] chip_sel,
  input  logic       fault_en,
  input  logic [3:0] fault_pin,
  inout  wire        Pin1,
  inout  wire        Pin2,
  inout  wire        Pin3,
  inout  wire        Pin4,
  inout  wire        Pin5,
  inout  wire        Pin6,
  inout  wire        Pin8,
  inout  wire        Pin9,
  inout  wire        Pin10,
  inout  wire        Pin11,
  inout  wire        Pin12,
  inout  wire        Pin13,
  output logic       active
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_e state, state_n;
  chip_e sel_q, sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [11:0] pins_in, s, pin_q, eval, quad, nor_v, inv, ffv, oe, fmask, drv;
  logic [1:0] clk_prev;
  logic fault_en_q;
  logic [3:0] fault_pin_q;
  logic q1, qn1, q2, qn2, ff_run, rise1, rise2;
  assign pins_in = {Pin13, Pin12, Pin11, Pin10, Pin9, Pin8, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};
  dip14_chip_emulator_pin_sync #(.STAGES(SYNC_STAGES), .WIDTH(12)) u_sync (
    .Clk(Clk),
    .Reset(Reset),
    .d(pins_in),
    .q(s)
  );
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= S_IDLE;
      sel_q <= CHIP_NONE;
      cnt <= '0;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    sel_n = sel_q;
    cnt_n = cnt;
    if (chip_sel == 3'd0) state_n = S_IDLE;
    else if (state == S_IDLE || chip_sel != sel_q) begin
      state_n = S_SETTLE;
      sel_n = chip_e'(chip_sel);
      cnt_n = '0;
    end else if (state == S_SETTLE) begin
      cnt_n = cnt + 1'b1;
      state_n = (cnt == CW'(SETTLE_CYCLES - 1)) ? S_ACTIVE : S_SETTLE;
    end
  end
  always_comb begin
    quad = '0;
    nor_v = '0;
    inv = '0;
    quad[P3] = gate(sel_q, s[P1], s[P2]);
    quad[P6] = gate(sel_q, s[P4], s[P5]);
    quad[P8] = gate(sel_q, s[P9], s[P10]);
    quad[P11] = gate(sel_q, s[P12], s[P13]);
    nor_v[P1] = ~(s[P2] | s[P3]);
    nor_v[P4] = ~(s[P5] | s[P6]);
    nor_v[P10] = ~(s[P8] | s[P9]);
    nor_v[P13] = ~(s[P11] | s[P12]);
    inv[P2] = ~s[P1];
    inv[P4] = ~s[P3];
    inv[P6] = ~s[P5];
    inv[P8] = ~s[P9];
    inv[P10] = ~s[P11];
    inv[P12] = ~s[P13];
    eval = (sel_q == CHIP_7402) ? nor_v : (sel_q == CHIP_7404) ? inv : quad;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pin_q <= '0;
      clk_prev <= '0;
      fault_en_q <= 1'b0;
      fault_pin_q <= '0;
    end else begin
      pin_q <= eval;
      clk_prev <= {s[P11], s[P3]};
      fault_en_q <= fault_en;
      fault_pin_q <= fault_pin;
    end
  end
  assign ff_run = (state == S_ACTIVE) && (sel_q == CHIP_7474);
  assign rise1 = s[P3] & ~clk_prev[0];
  assign rise2 = s[P11] & ~clk_prev[1];
  // Asynchronous PREn/CLRn of the real part become level checks on the synchronized pins.
  always_ff @(posedge Clk) begin
    if (!Reset || !ff_run) begin
      q1 <= 1'b0;
      qn1 <= 1'b1;
      q2 <= 1'b0;
      qn2 <= 1'b1;
    end else begin
      q1 <= !s[P4] ? 1'b1 : !s[P1] ? 1'b0 : rise1 ? s[P2] : q1;
      qn1 <= !s[P1] ? 1'b1 : !s[P4] ? 1'b0 : rise1 ? ~s[P2] : qn1;
      q2 <= !s[P10] ? 1'b1 : !s[P13] ? 1'b0 : rise2 ? s[P12] : q2;
      qn2 <= !s[P13] ? 1'b1 : !s[P10] ? 1'b0 : rise2 ? ~s[P12] : qn2;
    end
  end
  assign ffv = {4'b0, q2, qn2, qn1, q1, 4'b0};
  assign oe = (state == S_ACTIVE) ? out_mask(sel_q) : 12'h000;
  assign fmask = fault_en_q ? (pin_bit(fault_pin_q) & oe) : 12'h000;
  assign drv = ((sel_q == CHIP_7474) ? ffv : pin_q) ^ fmask;
  assign active = (state == S_ACTIVE);
  assign Pin1 = oe[P1] ? drv[P1] : 1'bz;
  assign Pin2 = oe[P2] ? drv[P2] : 1'bz;
  assign Pin3 = oe[P3] ? drv[P3] : 1'bz;
  assign Pin4 = oe[P4] ? drv[P4] : 1'bz;
  assign Pin5 = oe[P5] ? drv[P5] : 1'bz;
  assign Pin6 = oe[P6] ? drv[P6] : 1'bz;
  assign Pin8 = oe[P8] ? drv[P8] : 1'bz;
  assign Pin9 = oe[P9] ? drv[P9] : 1'bz;
  assign Pin10 = oe[P10] ? drv[P10] : 1'bz;
  assign Pin11 = oe[P11] ? drv[P11] : 1'bz;
  assign Pin12 = oe[P12] ? drv[P12] : 1'bz;
  assign Pin13 = oe[P13] ? drv[P13] : 1'bz;
endmodule

// File: tb/tb_dip14_chip_emulator.sv
// tb_dip14_chip_emulator: directed checks of the DIP14 emulator; undriven pins are pulled up so hi-Z reads 1
module tb_dip14_chip_emulator;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic [2:0] chip_sel = 3'd0;
  logic fault_en = 1'b0;
  logic [3:0] fault_pin = 4'd0;
  logic active;
  logic [11:0] den = '0;
  logic [11:0] dval = '0;
  int checks = 0;
  int failures = 0;
  wire w1, w2, w3, w4, w5, w6, w8, w9, w10, w11, w12, w13;
  wire [11:0] rd = {w13, w12, w11, w10, w9, w8, w6, w5, w4, w3, w2, w1};
  always #10 Clk = ~Clk;
  assign w1 = den[0] ? dval[0] : 1'bz;
  assign w2 = den[1] ? dval[1] : 1'bz;
  assign w3 = den[2] ? dval[2] : 1'bz;
  assign w4 = den[3] ? dval[3] : 1'bz;
  assign w5 = den[4] ? dval[4] : 1'bz;
  assign w6 = den[5] ? dval[5] : 1'bz;
  assign w8 = den[6] ? dval[6] : 1'bz;
  assign w9 = den[7] ? dval[7] : 1'bz;
  assign w10 = den[8] ? dval[8] : 1'bz;
  assign w11 = den[9] ? dval[9] : 1'bz;
  assign w12 = den[10] ? dval[10] : 1'bz;
  assign w13 = den[11] ? dval[11] : 1'bz;
  pullup (w1);
  pullup (w2);
  pullup (w3);
  pullup (w4);
  pullup (w5);
  pullup (w6);
  pullup (w8);
  pullup (w9);
  pullup (w10);
  pullup (w11);
  pullup (w12);
  pullup (w13);
  dip14_chip_emulator dut (
    .Clk(Clk), .Reset(Reset), .chip_sel(chip_sel), .fault_en(fault_en), .fault_pin(fault_pin),
    .Pin1(w1), .Pin2(w2), .Pin3(w3), .Pin4(w4), .Pin5(w5), .Pin6(w6),
    .Pin8(w8), .Pin9(w9), .Pin10(w10), .Pin11(w11), .Pin12(w12), .Pin13(w13),
    .active(active)
  );
  function automatic int ix(int n);
    return n < 7 ? n - 1 : n - 2;
  endfunction
  function automatic logic pin(int n);
    return rd[ix(n)];
  endfunction
  task automatic drive(int n, logic v);
    den[ix(n)] = 1'b1;
    dval[ix(n)] = v;
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic test_reset();
    Reset = 1'b0;
    cyc(3);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (rd !== 12'hfff) begin failures++; $display("FAIL reset_pins_z got=%h exp=fff", rd); end
    Reset = 1'b1;
    cyc(2);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL idle_active got=%b exp=0", active); end
  endtask
  task automatic test_nand_latency();
    drive(1, 1); drive(2, 1); drive(4, 0); drive(5, 0);
    drive(9, 0); drive(10, 0); drive(12, 0); drive(13, 0);
    chip_sel = 3'd1;
    cyc(4);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL settle_active got=%b exp=0", active); end
    checks++; if (pin(3) !== 1'b1) begin failures++; $display("FAIL settle_pin3_z got=%b exp=1", pin(3)); end
    cyc(1);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL nand_active got=%b exp=1", active); end
    checks++; if (pin(3) !== 1'b0) begin failures++; $display("FAIL nand_11 got=%b exp=0", pin(3)); end
    checks++; if (pin(6) !== 1'b1) begin failures++; $display("FAIL nand_00 got=%b exp=1", pin(6)); end
    drive(1, 0);
    cyc(2);
    checks++; if (pin(3) !== 1'b0) begin failures++; $display("FAIL nand_lat_early_fall got=%b exp=0", pin(3)); end
    cyc(1);
    checks++; if (pin(3) !== 1'b1) begin failures++; $display("FAIL nand_lat_rise got=%b exp=1", pin(3)); end
    drive(1, 1);
    cyc(2);
    checks++; if (pin(3) !== 1'b1) begin failures++; $display("FAIL nand_lat_early_rise got=%b exp=1", pin(3)); end
    cyc(1);
    checks++; if (pin(3) !== 1'b0) begin failures++; $display("FAIL nand_lat_fall got=%b exp=0", pin(3)); end
  endtask
  task automatic test_select_switch();
    drive(4, 0); drive(5, 1); drive(9, 1); drive(10, 0); drive(12, 0); drive(13, 0);
    cyc(4);
    chip_sel = 3'd6;
    cyc(1);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL switch_active_first got=%b exp=0", active); end
    checks++; if (pin(3) !== 1'b1) begin failures++; $display("FAIL switch_pin3_z_first got=%b exp=1", pin(3)); end
    cyc(3);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL switch_active_last got=%b exp=0", active); end
    checks++; if (pin(11) !== 1'b1) begin failures++; $display("FAIL switch_pin11_z_last got=%b exp=1", pin(11)); end
    cyc(1);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL xor_active got=%b exp=1", active); end
    checks++; if (pin(3) !== 1'b0) begin failures++; $display("FAIL xor_11 got=%b exp=0", pin(3)); end
    checks++; if (pin(6) !== 1'b1) begin failures++; $display("FAIL xor_01 got=%b exp=1", pin(6)); end
    checks++; if (pin(8) !== 1'b1) begin failures++; $display("FAIL xor_10 got=%b exp=1", pin(8)); end
    checks++; if (pin(11) !== 1'b0) begin failures++; $display("FAIL xor_00 got=%b exp=0", pin(11)); end
  endtask
  task automatic test_nor_exhaustive();
    int outs[4] = '{1, 4, 10, 13};
    logic a, b, e;
    chip_sel = 3'd2;
    cyc(1);
    den = '0;
    for (int ab = 0; ab < 4; ab++) begin
      a = ab[1];
      b = ab[0];
      e = ~(a | b);
      drive(2, a); drive(3, b); drive(5, a); drive(6, b);
      drive(8, a); drive(9, b); drive(11, a); drive(12, b);
      cyc(ab == 0 ? 6 : 4);
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (pin(outs[g]) !== e) begin failures++; $display("FAIL nor_pin%0d_ab%0d got=%b exp=%b", outs[g], ab, pin(outs[g]), e); end
      end
      checks++; if (pin(2) !== a) begin failures++; $display("FAIL nor_pin2_undriven_ab%0d got=%b exp=%b", ab, pin(2), a); end
      checks++; if (pin(3) !== b) begin failures++; $display("FAIL nor_pin3_undriven_ab%0d got=%b exp=%b", ab, pin(3), b); end
    end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL nor_active got=%b exp=1", active); end
  endtask
  task automatic test_flipflop();
    chip_sel = 3'd7;
    cyc(1);
    den = '0;
    drive(1, 1); drive(2, 0); drive(3, 0); drive(4, 1);
    drive(10, 1); drive(11, 0); drive(12, 0); drive(13, 1);
    cyc(6);
    checks++; if ({pin(5), pin(6), pin(9), pin(8)} !== 4'b0101) begin failures++; $display("FAIL ff_initial got=%b exp=0101", {pin(5), pin(6), pin(9), pin(8)}); end
    drive(2, 1); cyc(1); drive(3, 1);
    cyc(2);
    checks++; if (pin(5) !== 1'b0) begin failures++; $display("FAIL ff1_d1_early got=%b exp=0", pin(5)); end
    cyc(1);
    checks++; if ({pin(5), pin(6)} !== 2'b10) begin failures++; $display("FAIL ff1_d1_edge got=%b exp=10", {pin(5), pin(6)}); end
    drive(3, 0); drive(2, 0); cyc(1); drive(3, 1); cyc(3);
    checks++; if ({pin(5), pin(6)} !== 2'b01) begin failures++; $display("FAIL ff1_d0_edge got=%b exp=01", {pin(5), pin(6)}); end
    drive(1, 0); drive(2, 1); cyc(1); drive(3, 0); cyc(1); drive(3, 1); cyc(3);
    checks++; if ({pin(5), pin(6)} !== 2'b01) begin failures++; $display("FAIL ff1_clr_overrides got=%b exp=01", {pin(5), pin(6)}); end
    drive(4, 0); cyc(3);
    checks++; if ({pin(5), pin(6)} !== 2'b11) begin failures++; $display("FAIL ff1_pre_clr_both got=%b exp=11", {pin(5), pin(6)}); end
    drive(1, 1); cyc(3);
    checks++; if ({pin(5), pin(6)} !== 2'b10) begin failures++; $display("FAIL ff1_preset got=%b exp=10", {pin(5), pin(6)}); end
    drive(4, 1);
    drive(12, 1); cyc(1); drive(11, 1); cyc(3);
    checks++; if ({pin(9), pin(8)} !== 2'b10) begin failures++; $display("FAIL ff2_d1_edge got=%b exp=10", {pin(9), pin(8)}); end
    chip_sel = 3'd0; cyc(1); chip_sel = 3'd7; cyc(5);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL ff_reselect_active got=%b exp=1", active); end
    checks++; if ({pin(5), pin(6), pin(9), pin(8)} !== 4'b0101) begin failures++; $display("FAIL ff_reselect_cleared got=%b exp=0101", {pin(5), pin(6), pin(9), pin(8)}); end
  endtask
  task automatic test_fault();
    chip_sel = 3'd3;
    cyc(1);
    den = '0;
    drive(1, 1); drive(3, 1); drive(5, 0); drive(9, 0); drive(11, 0); drive(13, 0);
    fault_en = 1'b1;
    fault_pin = 4'd4;
    cyc(6);
    checks++; if (pin(4) !== 1'b1) begin failures++; $display("FAIL fault_pin4_inverted got=%b exp=1", pin(4)); end
    checks++; if (pin(2) !== 1'b0) begin failures++; $display("FAIL fault_pin2_untouched got=%b exp=0", pin(2)); end
    fault_pin = 4'd3;
    cyc(2);
    checks++; if (pin(4) !== 1'b0) begin failures++; $display("FAIL fault_input_pin4 got=%b exp=0", pin(4)); end
    checks++; if (pin(3) !== 1'b1) begin failures++; $display("FAIL fault_input_pin3 got=%b exp=1", pin(3)); end
    fault_pin = 4'd14;
    cyc(2);
    checks++; if (pin(4) !== 1'b0) begin failures++; $display("FAIL fault_pin14 got=%b exp=0", pin(4)); end
    fault_en = 1'b0;
    fault_pin = 4'd4;
    cyc(2);
    checks++; if (pin(4) !== 1'b0) begin failures++; $display("FAIL fault_disabled got=%b exp=0", pin(4)); end
  endtask
  task automatic test_reset_mid();
    Reset = 1'b0;
    cyc(1);
    Reset = 1'b1;
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%b exp=0", active); end
    checks++; if ({pin(2), pin(4)} !== 2'b11) begin failures++; $display("FAIL midreset_pins_z got=%b exp=11", {pin(2), pin(4)}); end
    cyc(4);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_settle got=%b exp=0", active); end
    cyc(1);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL midreset_resume got=%b exp=1", active); end
    checks++; if ({pin(2), pin(4)} !== 2'b00) begin failures++; $display("FAIL midreset_outputs got=%b exp=00", {pin(2), pin(4)}); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_nand_latency();
    test_select_switch();
    test_nor_exhaustive();
    test_flipflop();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
